// File: rtl/cla_pipe_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_adder_if
//  Description : Operand/result stream bundle for cla_pipe_adder. The master
//                side issues operands and accepts results; the slave side is
//                the adder itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_adder
//  Description : Pipelined carry-lookahead adder/subtractor. Each stage
//                resolves one BLK-bit lookahead block and registers the block
//                carry for the next stage. Valid/ready stream with full
//                back-pressure; flags for carry, signed overflow and zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  cla_pipe_adder_if.slave bus
);

  localparam int BLK_SAFE = (BLK < 1) ? 1 : BLK;
  localparam int NUM_BLK  = (WIDTH / BLK_SAFE < 1) ? 1 : (WIDTH / BLK_SAFE);

  if ((BLK < 1) || ((WIDTH % BLK_SAFE) != 0) || (WIDTH < BLK_SAFE)) begin : g_param_check
    $fatal(1, "cla_pipe_adder: WIDTH must be a non-zero multiple of BLK (BLK >= 1)");
  end

  // One lookahead block: every carry is a sum-of-products of the block
  // generate/propagate terms and the incoming carry, so no carry chains
  // through the block. Returns {carry into MSB, carry out, sum bits}.
  function automatic logic [BLK+1:0] cla_blk(
    input logic [BLK-1:0] x,
    input logic [BLK-1:0] y,
    input logic           ci
  );
    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   c;
    logic           pp;
    g = x & y;
    p = x ^ y;
    c = '0;
    for (int i = 0; i <= BLK; i++) begin
      pp = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        c[i] = c[i] | (pp & g[j]);
        pp   = pp & p[j];
      end
      c[i] = c[i] | (pp & ci);
    end
    return {c[BLK-1], c[BLK], p ^ c[BLK-1:0]};
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  // Subtraction is A + ~B + 1; the external carry-in is ignored then.
  assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
  assign w_cin_eff = bus.sub | bus.cin;

  // The whole pipe moves together unless a finished result is being held.
  assign w_adv        = !g_stage[NUM_BLK-1].r_vld || bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar s = 0; s < NUM_BLK; s++) begin : g_stage
    // Operand bits still unconsumed on entry to this stage, and after it.
    localparam int IN_W  = WIDTH - s * BLK;
    localparam int REM_W = IN_W - BLK;

    logic                 w_vld_in;
    logic                 w_c_in;
    logic [IN_W-1:0]      w_a_in;
    logic [IN_W-1:0]      w_b_in;
    logic [BLK+1:0]       w_res;
    logic [(s+1)*BLK-1:0] w_sum_nxt;
    logic                 r_vld;
    logic                 r_c;
    logic [(s+1)*BLK-1:0] r_sum;

    if (s == 0) begin : g_src
      assign w_vld_in  = bus.in_valid;
      assign w_a_in    = bus.a;
      assign w_b_in    = w_b_eff;
      assign w_c_in    = w_cin_eff;
      assign w_sum_nxt = w_res[BLK-1:0];
    end else begin : g_src
      assign w_vld_in  = g_stage[s-1].r_vld;
      assign w_a_in    = g_stage[s-1].g_rem.r_a;
      assign w_b_in    = g_stage[s-1].g_rem.r_b;
      assign w_c_in    = g_stage[s-1].r_c;
      assign w_sum_nxt = {w_res[BLK-1:0], g_stage[s-1].r_sum};
    end

    assign w_res = cla_blk(w_a_in[BLK-1:0], w_b_in[BLK-1:0], w_c_in);

    // Stage register: valid, resolved low sum bits and this block's carry-out.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_vld <= w_vld_in;
        r_c   <= w_res[BLK];
        r_sum <= w_sum_nxt;
      end
    end

    if (REM_W > 0) begin : g_rem
      logic [REM_W-1:0] r_a;
      logic [REM_W-1:0] r_b;

      // Forward the operand bits later stages still need.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a_in[IN_W-1:BLK];
          r_b <= w_b_in[IN_W-1:BLK];
        end
      end
    end else begin : g_last
      logic r_cmsb;
      logic r_zero;

      // Final stage also registers the carry into the MSB and the zero flag.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cmsb <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_adv) begin
          r_cmsb <= w_res[BLK+1];
          r_zero <= (w_sum_nxt == '0);
        end
      end
    end
  end

  assign bus.out_valid = g_stage[NUM_BLK-1].r_vld;
  assign bus.sum       = g_stage[NUM_BLK-1].r_sum;
  assign bus.cout      = g_stage[NUM_BLK-1].r_c;
  assign bus.ovf       = g_stage[NUM_BLK-1].g_last.r_cmsb ^ g_stage[NUM_BLK-1].r_c;
  assign bus.zero      = g_stage[NUM_BLK-1].g_last.r_zero;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_adder
//  Description : Self-checking bench for cla_pipe_adder: 32/8 main instance
//                against a result-level reference model, plus 16/16 and 24/8
//                instances for alternate pipeline depths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

  localparam int NB = 4;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  bit   pv_v[NB];
  exp_t pv_e[NB];

  cla_pipe_adder_if #(.WIDTH(32)) bus32 ();
  cla_pipe_adder_if #(.WIDTH(16)) bus16 ();
  cla_pipe_adder_if #(.WIDTH(24)) bus24 ();

  cla_pipe_adder #(.WIDTH(32), .BLK(8))  u_dut   (.clk(clk), .rst(rst), .bus(bus32));
  cla_pipe_adder #(.WIDTH(16), .BLK(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  cla_pipe_adder #(.WIDTH(24), .BLK(8))  u_dut24 (.clk(clk), .rst(rst), .bus(bus24));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic modulo 2^w, signed range test for ovf.
  function automatic exp_t ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic ci, input logic sb);
    longint m, ua, ub, tot, sa, sbv, r;
    exp_t   e;
    m   = longint'(1) << w;
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    tot = sb ? (ua + m - ub) : (ua + ub + (ci ? 1 : 0));
    e.co = (tot >= m);
    e.s  = 32'(tot % m);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    r   = sb ? (sa - sbv) : (sa + sbv + (ci ? 1 : 0));
    e.ov = (r < -(m / 2)) || (r >= m / 2);
    e.z  = (e.s == 32'd0);
    return e;
  endfunction

  // One cycle on the 32-bit instance, entered just after a falling edge.
  // The bench keeps its own picture of the NB-deep pipe and compares the
  // output slot every cycle (so held outputs are rechecked while stalled).
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic sb, input bit ordy,
                      input bit use_fix, input exp_t fix);
    bit   adv;
    exp_t e;
    bus32.in_valid  = v;
    bus32.a         = a;
    bus32.b         = b;
    bus32.cin       = ci;
    bus32.sub       = sb;
    bus32.out_ready = ordy;
    #1;
    adv = !pv_v[NB-1] || ordy;
    check_eq("out_valid", {63'd0, bus32.out_valid}, {63'd0, pv_v[NB-1]});
    check_eq("in_ready", {63'd0, bus32.in_ready}, {63'd0, adv});
    if (pv_v[NB-1]) begin
      check_eq("sum",  {32'd0, bus32.sum},  {32'd0, pv_e[NB-1].s});
      check_eq("cout", {63'd0, bus32.cout}, {63'd0, pv_e[NB-1].co});
      check_eq("ovf",  {63'd0, bus32.ovf},  {63'd0, pv_e[NB-1].ov});
      check_eq("zero", {63'd0, bus32.zero}, {63'd0, pv_e[NB-1].z});
    end
    e = use_fix ? fix : ref_model(32, a, b, ci, sb);
    if (adv) begin
      for (int k = NB - 1; k > 0; k--) begin
        pv_v[k] = pv_v[k-1];
        pv_e[k] = pv_e[k-1];
      end
      pv_v[0] = v;
      pv_e[0] = e;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    exp_t  e16 [16];
    exp_t  e24 [16];
    logic [31:0] ra, rb;
    logic  rc, rs;

    for (int k = 0; k < NB; k++) begin
      pv_v[k] = 1'b0;
      pv_e[k] = '0;
    end
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b1;
    bus24.in_valid = 1'b0; bus24.a = '0; bus24.b = '0; bus24.cin = 1'b0; bus24.sub = 1'b0; bus24.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", {63'd0, bus32.out_valid}, 64'd0);
    check_eq("rst_sum",  {32'd0, bus32.sum}, 64'd0);
    check_eq("rst_cout", {63'd0, bus32.cout}, 64'd0);
    check_eq("rst_ovf",  {63'd0, bus32.ovf}, 64'd0);
    check_eq("rst_zero", {63'd0, bus32.zero}, 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", {63'd0, bus32.in_ready}, 64'd1);
    @(negedge clk);

    // Directed boundary vectors with hand-derived results
    step(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1, '{32'h0, 1'b1, 1'b0, 1'b1});
    idle(5);
    step(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1, '{32'h8000_0000, 1'b0, 1'b1, 1'b0});
    step(1'b1, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
    step(1'b1, 32'h5,         32'h7, 1'b1, 1'b1, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    idle(5);

    // Full-throughput random stream
    for (int i = 0; i < 20; i++)
      step(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1, 1'b0, '0);
    idle(5);

    // Random valid and back-pressure
    for (int i = 0; i < 80; i++)
      step(($urandom_range(3) != 0), $urandom, $urandom, 1'($urandom), 1'($urandom),
           1'($urandom), 1'b0, '0);
    idle(6);

    // Fill the pipe while stalled, then reset mid-stream
    for (int i = 0; i < NB + 1; i++)
      step(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_out_valid", {63'd0, bus32.out_valid}, 64'd0);
    check_eq("async_rst_sum", {32'd0, bus32.sum}, 64'd0);
    for (int k = 0; k < NB; k++) pv_v[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 1'b1, '{32'h2345_678A, 1'b0, 1'b0, 1'b0});
    idle(7);

    // Alternate depths: 16/16 (latency 1) and 24/8 (latency 3)
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        ra = 32'hFFFF; rb = 32'h1; rc = 1'b0; rs = 1'b0;
      end else begin
        ra = $urandom & 32'hFFFF; rb = $urandom & 32'hFFFF; rc = 1'($urandom); rs = 1'($urandom);
      end
      bus16.in_valid = 1'b1; bus16.a = ra[15:0]; bus16.b = rb[15:0]; bus16.cin = rc; bus16.sub = rs;
      e16[i] = ref_model(16, ra, rb, rc, rs);
      ra = $urandom & 32'hFF_FFFF; rb = $urandom & 32'hFF_FFFF; rc = 1'($urandom); rs = 1'($urandom);
      bus24.in_valid = 1'b1; bus24.a = ra[23:0]; bus24.b = rb[23:0]; bus24.cin = rc; bus24.sub = rs;
      e24[i] = ref_model(24, ra, rb, rc, rs);
      #1;
      check_eq("w16_out_valid", {63'd0, bus16.out_valid}, {63'd0, (i >= 1)});
      check_eq("w24_out_valid", {63'd0, bus24.out_valid}, {63'd0, (i >= 3)});
      if (i >= 1) begin
        check_eq("w16_sum",  {48'd0, bus16.sum},  {32'd0, e16[i-1].s});
        check_eq("w16_cout", {63'd0, bus16.cout}, {63'd0, e16[i-1].co});
        check_eq("w16_ovf",  {63'd0, bus16.ovf},  {63'd0, e16[i-1].ov});
        check_eq("w16_zero", {63'd0, bus16.zero}, {63'd0, e16[i-1].z});
      end
      if (i == 1) begin
        check_eq("w16_wrap_sum",  {48'd0, bus16.sum},  64'd0);
        check_eq("w16_wrap_cout", {63'd0, bus16.cout}, 64'd1);
      end
      if (i >= 3) begin
        check_eq("w24_sum",  {40'd0, bus24.sum},  {32'd0, e24[i-3].s});
        check_eq("w24_cout", {63'd0, bus24.cout}, {63'd0, e24[i-3].co});
        check_eq("w24_ovf",  {63'd0, bus24.ovf},  {63'd0, e24[i-3].ov});
        check_eq("w24_zero", {63'd0, bus24.zero}, {63'd0, e24[i-3].z});
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
